// File: rtl/handshake_pkg.sv
// Shared definitions for the request/response accumulator slave.
package handshake_pkg;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    RSP_OKAY = 2'b00,
    RSP_OVF  = 2'b01
  } rsp_code_e;
endpackage

// File: rtl/resp_fifo.sv
// Response queue: storage, wrapping pointers and occupancy count.
module resp_fifo #(
  parameter int unsigned W     = 34,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  last_q, last_d;
  logic          do_push, do_pop;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    last_d   = last_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      last_d   = mem_q[rd_ptr_q];
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // last popped entry keeps the outputs steady while the queue is empty
    rdata = empty ? last_q : mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/handshake_resp_slave.sv
// Accumulating slave: each accepted request returns the running sum and a carry flag.
module handshake_resp_slave
  import handshake_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_code
);
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W:0]   sum;
  rsp_code_e         code;
  logic [DATA_W+1:0] push_entry, head;
  logic              full, empty, accept;

  always_comb begin
    // rst gating keeps ready low throughout an asynchronous reset
    req_ready  = !full && !rst;
    accept     = req_valid && req_ready;
    sum        = {1'b0, acc_q} + {1'b0, req_data};
    code       = sum[DATA_W] ? RSP_OVF : RSP_OKAY;
    push_entry = {code, sum[DATA_W-1:0]};
    acc_d      = accept ? sum[DATA_W-1:0] : acc_q;
    rsp_valid  = !empty;
    rsp_data   = head[DATA_W-1:0];
    rsp_code   = head[DATA_W+1:DATA_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  resp_fifo #(
    .W     (DATA_W + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (rsp_ready),
    .wdata (push_entry),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );
endmodule

// File: tb/tb_handshake_resp_slave.sv
// Scoreboard bench for handshake_resp_slave with a running-sum reference model.
module tb_handshake_resp_slave;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] req_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_code;

  handshake_resp_slave #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_code  (rsp_code)
  );

  always #5 clk = ~clk;

  int unsigned   nchk = 0;
  int unsigned   nerr = 0;
  logic [DW+1:0] sb [$];
  logic [DW-1:0] macc;
  int unsigned   mcnt;
  logic          prev_stall;
  logic [DW+1:0] prev_out;
  logic          last_acc;
  int unsigned   vcyc;
  int unsigned   nacc;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data",  64'(rsp_data),  64'd0);
    chk("rst_rsp_code",  64'(rsp_code),  64'd0);
    chk("rst_count",     64'(dut.u_fifo.count_q), 64'd0);
    chk("rst_acc",       64'(dut.acc_q), 64'd0);
    sb.delete();
    macc = '0;
    mcnt = 0;
    prev_stall = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One clock: check at the falling edge, update model for the handshakes seen there.
  task automatic cycle();
    logic [DW:0]   s;
    logic [DW+1:0] e;
    @(negedge clk);
    chk("rsp_valid", 64'(rsp_valid), 64'(mcnt != 0));
    chk("req_ready", 64'(req_ready), 64'(mcnt != DEPTH));
    chk("count",     64'(dut.u_fifo.count_q), 64'(mcnt));
    if (prev_stall) begin
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_out",   64'({rsp_code, rsp_data}), 64'(prev_out));
    end
    if (rsp_valid) vcyc++;
    prev_stall = rsp_valid && !rsp_ready;
    prev_out   = {rsp_code, rsp_data};
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        chk("rsp", 64'({rsp_code, rsp_data}), 64'(e));
      end
      mcnt--;
    end
    last_acc = req_valid && req_ready;
    if (last_acc) begin
      s = {1'b0, macc} + {1'b0, req_data};
      macc = s[DW-1:0];
      sb.push_back({1'b0, s[DW], s[DW-1:0]});
      mcnt++;
      nacc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 40 && mcnt != 0; i++) cycle();
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_data = '0;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // single request, response visible for exactly one cycle
    vcyc = 0;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_data  = 32'h0000_0005;
    cycle();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    chk("t1_vcyc", 64'(vcyc), 64'd1);
    chk("t1_empty", 64'(sb.size()), 64'd0);

    // carry out of the top bit
    req_valid = 1'b1;
    req_data  = 32'hFFFF_FFF0;
    cycle();
    req_data  = 32'h0000_0020;
    cycle();
    drain();

    // fill with rsp_ready low, then release
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_data  = 32'd1;
    nacc = 0;
    for (int i = 0; i < 7; i++) begin
      cycle();
      if (last_acc) req_data = req_data + 1;
    end
    chk("t3_accepts", 64'(nacc), 64'd4);
    chk("t3_data_next", 64'(req_data), 64'd5);
    rsp_ready = 1'b1;
    for (int i = 0; i < 10 && nacc < 5; i++) cycle();
    chk("t3_fifth", 64'(nacc), 64'd5);
    req_valid = 1'b0;
    drain();
    chk("t3_acc", 64'(dut.acc_q), 64'd15);

    // steady state at count 2 with pointer wrap
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_data  = 32'h10;
    cycle();
    req_data  = 32'h20;
    cycle();
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_data = 32'h100 + 32'(i);
      cycle();
    end
    chk("t4_count", 64'(dut.u_fifo.count_q), 64'd2);
    chk("t4_rdptr", 64'(dut.u_fifo.rd_ptr_q), 64'd0);
    drain();

    // reset with entries queued
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_data  = 32'h33;
    for (int i = 0; i < 3; i++) cycle();
    req_valid = 1'b0;
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_data  = 32'h0000_0007;
    cycle();
    req_valid = 1'b0;
    drain();
    chk("t5_acc", 64'(dut.acc_q), 64'd7);

    // random valid/ready traffic
    for (int i = 0; i < 10000; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      rsp_ready = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
      if (i % 500 < 100) rsp_ready = 1'($urandom_range(0, 1)) & 1'($urandom_range(0, 1));
      req_data  = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 255));
      cycle();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish (checks=%0d)", nchk);
    $fatal(1);
  end
endmodule
